// File: rtl/tile_bram_port_master.sv
// Host-side initiator for a tile's external BRAM port: moves one block-transfer
// command of 16-bit words between valid/ready streams and the tile's port A.
module tile_bram_port_master #(
    parameter int TILE_DIM = 2,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [7:0]        cmd_i,
    input  logic [7:0]        cmd_j,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              external,
    output logic [7:0]        BRAM_i,
    output logic [7:0]        BRAM_j,
    output logic              WEA,
    output logic [ADDR_W-1:0] ADDRA,
    output logic [DATA_W-1:0] DIA,
    input  logic [DATA_W-1:0] DOA,
    output logic              WEB,
    output logic [ADDR_W-1:0] ADDRB,
    output logic [DATA_W-1:0] DIB
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [7:0] TILE_DIM_C = 8'(TILE_DIM);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic [7:0]         bram_i_q, bram_i_d;
    logic [7:0]         bram_j_q, bram_j_d;
    logic               err_lat_q, err_lat_d;
    logic               inflight_q;

    logic [DATA_W-1:0]  fifo_mem_q [2];
    logic               fifo_wptr_q;
    logic               fifo_rptr_q;
    logic [1:0]         fifo_cnt_q;

    logic               cmd_ready_q, wr_ready_q, busy_q, external_q, done_q, err_q;

    logic               wr_fire_s;
    logic               pop_s;
    logic               issue_s;
    logic               illegal_s;
    logic [2:0]         occ_s;

    // Handshake qualifiers and read-issue throttle.
    always_comb begin
        wr_fire_s = (state_q == ST_WRITE) && wr_valid;
        pop_s     = (fifo_cnt_q != 2'd0) && rd_ready;
        // Words owed to the FIFO once this cycle's pop is taken out; never exceed 2.
        occ_s     = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s   = (state_q == ST_READ) && (remain_q != {LEN_W{1'b0}}) && (occ_s < 3'd2);
        illegal_s = (cmd_len == {LEN_W{1'b0}}) || (cmd_i >= TILE_DIM_C) || (cmd_j >= TILE_DIM_C);
    end

    // Next-state and command-context update.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        bram_i_d   = bram_i_q;
        bram_j_d   = bram_j_q;
        err_lat_d  = err_lat_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cur_addr_d = cmd_addr;
                    remain_d   = cmd_len;
                    bram_i_d   = cmd_i;
                    bram_j_d   = cmd_j;
                    err_lat_d  = illegal_s;
                    if (illegal_s) begin
                        state_d = ST_FIN;
                    end else if (cmd_write) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_fire_s) begin
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    remain_d   = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    remain_d   = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (occ_s == 3'd0) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, command context and status outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= {ADDR_W{1'b0}};
            remain_q    <= {LEN_W{1'b0}};
            bram_i_q    <= 8'd0;
            bram_j_q    <= 8'd0;
            err_lat_q   <= 1'b0;
            inflight_q  <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            external_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remain_q    <= remain_d;
            bram_i_q    <= bram_i_d;
            bram_j_q    <= bram_j_d;
            err_lat_q   <= err_lat_d;
            inflight_q  <= issue_s;
            cmd_ready_q <= (state_d == ST_IDLE);
            wr_ready_q  <= (state_d == ST_WRITE);
            busy_q      <= (state_d != ST_IDLE);
            external_q  <= (state_d == ST_WRITE) || (state_d == ST_READ) || (state_d == ST_DRAIN);
            done_q      <= (state_d == ST_FIN);
            err_q       <= (state_d == ST_FIN) && err_lat_d;
        end
    end

    // Two-entry read FIFO; DOA for the address issued last cycle is pushed now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_mem_q[0] <= {DATA_W{1'b0}};
            fifo_mem_q[1] <= {DATA_W{1'b0}};
            fifo_wptr_q   <= 1'b0;
            fifo_rptr_q   <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (inflight_q) begin
                fifo_mem_q[fifo_wptr_q] <= DOA;
                fifo_wptr_q             <= ~fifo_wptr_q;
            end else begin
                fifo_wptr_q             <= fifo_wptr_q;
            end
            if (pop_s) begin
                fifo_rptr_q <= ~fifo_rptr_q;
            end else begin
                fifo_rptr_q <= fifo_rptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};
        end
    end

    // Port A is driven combinationally in the cycle the word moves.
    always_comb begin
        WEA   = wr_fire_s;
        ADDRA = (wr_fire_s || issue_s) ? cur_addr_q : {ADDR_W{1'b0}};
        DIA   = wr_fire_s ? wr_data : {DATA_W{1'b0}};
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign busy      = busy_q;
    assign external  = external_q;
    assign done      = done_q;
    assign err       = err_q;
    assign BRAM_i    = bram_i_q;
    assign BRAM_j    = bram_j_q;
    assign rd_valid  = (fifo_cnt_q != 2'd0);
    assign rd_data   = fifo_mem_q[fifo_rptr_q];
    assign WEB       = 1'b0;
    assign ADDRB     = {ADDR_W{1'b0}};
    assign DIB       = {DATA_W{1'b0}};

endmodule

// File: tb/tb_tile_bram_port_master.sv
// Scoreboard bench for tile_bram_port_master: a bench-side BRAM plus a
// reference memory image predict every port-A write, read word and done/err.
module tb_tile_bram_port_master;

    localparam int TILE_DIM = 2;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [7:0]        cmd_i, cmd_j;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid, rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              done, err, busy, external;
    logic [7:0]        BRAM_i, BRAM_j;
    logic              WEA;
    logic [ADDR_W-1:0] ADDRA;
    logic [DATA_W-1:0] DIA;
    logic [DATA_W-1:0] DOA;
    logic              WEB;
    logic [ADDR_W-1:0] ADDRB;
    logic [DATA_W-1:0] DIB;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rd_mode = 0;
    int ph = 0;

    logic [41:0]       exp_wr[$];
    logic [DATA_W-1:0] exp_rd[$];
    logic              exp_done_err[$];
    int                exp_done_cyc[$];

    logic [DATA_W-1:0] bram    [0:3][0:1023];
    logic [DATA_W-1:0] ref_mem [0:3][0:1023];
    logic [1:0]        blk_s;

    tile_bram_port_master #(.TILE_DIM(TILE_DIM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_i(cmd_i), .cmd_j(cmd_j), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err), .busy(busy), .external(external),
        .BRAM_i(BRAM_i), .BRAM_j(BRAM_j), .WEA(WEA), .ADDRA(ADDRA), .DIA(DIA), .DOA(DOA),
        .WEB(WEB), .ADDRB(ADDRB), .DIB(DIB)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_word(int b, int a);
        return 16'((b * 1024 + a) * 37) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tile BRAM stand-in: read-first, one-cycle latency, one array per block.
    assign blk_s = {BRAM_i[0], BRAM_j[0]};
    initial begin
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 1024; a++)
                bram[b][a] <= init_word(b, a);
    end
    always @(posedge clk) begin
        if (WEA) bram[blk_s][ADDRA] <= DIA;
        DOA <= bram[blk_s][ADDRA];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Read-side backpressure: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rd_mode == 1) begin
                rd_ready = (ph % 4 == 0) || (ph % 4 == 3);
                ph++;
            end else if (rd_mode == 2) begin
                rd_ready = 1'($urandom_range(0, 1));
            end else begin
                rd_ready = 1'b1;
            end
        end
    end

    // Monitor: pop the scoreboard whenever the DUT presents a write, a read word or done.
    always @(negedge clk) begin
        if (reset) begin
            if (WEA) begin
                if (exp_wr.size() == 0) chk("unexpected_wea", {BRAM_i, BRAM_j, ADDRA, DIA}, 64'd0);
                else chk("wr_beat", {BRAM_i, BRAM_j, ADDRA, DIA}, exp_wr.pop_front());
            end
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) chk("unexpected_rd", {1'b1, rd_data}, 64'd0);
                else chk("rd_word", rd_data, exp_rd.pop_front());
            end
            if (done) begin
                if (exp_done_err.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    logic e;
                    int   c;
                    e = exp_done_err.pop_front();
                    c = exp_done_cyc.pop_front();
                    chk("done_err", err, e);
                    chk("done_ext_low", external, 1'b0);
                    if (c >= 0) chk("done_cycle", cyc, c);
                end
            end
        end
    end

    task automatic issue_cmd(input bit wr, input logic [7:0] i, input logic [7:0] j,
                             input logic [9:0] a, input logic [10:0] len, output int acc);
        @(posedge clk); #1;
        chk("cmd_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_i = i; cmd_j = j; cmd_addr = a; cmd_len = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        if (n >= 2000) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_write(input logic [7:0] i, input logic [7:0] j, input logic [9:0] a,
                            input int len, input logic [15:0] base, input bit seq, input bit gaps);
        int acc;
        int b = int'(i[0]) * 2 + int'(j[0]);
        logic [9:0] ad;
        logic [15:0] d;
        issue_cmd(1'b1, i, j, a, 11'(len), acc);
        for (int k = 0; k < len; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                wr_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            ad = a + 10'(k);
            d  = seq ? base + 16'(k) : 16'($urandom);
            wr_valid = 1'b1; wr_data = d;
            exp_wr.push_back({i, j, ad, d});
            ref_mem[b][ad] = d;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        exp_done_err.push_back(1'b0);
        exp_done_cyc.push_back(cyc);
        wait_idle();
    endtask

    task automatic do_read(input logic [7:0] i, input logic [7:0] j, input logic [9:0] a,
                           input int len, input int mode);
        int acc;
        int b = int'(i[0]) * 2 + int'(j[0]);
        rd_mode = mode;
        issue_cmd(1'b0, i, j, a, 11'(len), acc);
        for (int k = 0; k < len; k++) exp_rd.push_back(ref_mem[b][a + 10'(k)]);
        exp_done_err.push_back(1'b0);
        exp_done_cyc.push_back(mode == 0 ? acc + len + 2 : -1);
        if (mode == 0) begin
            @(negedge clk); @(negedge clk);
            chk("rd_valid_lat1", rd_valid, 1'b0);
            @(negedge clk);
            chk("rd_valid_lat2", rd_valid, 1'b1);
        end
        wait_idle();
    endtask

    task automatic do_illegal(input logic [7:0] i, input logic [7:0] j, input logic [10:0] len);
        int acc;
        issue_cmd(1'b1, i, j, 10'h020, len, acc);
        exp_done_err.push_back(1'b1);
        exp_done_cyc.push_back(acc);
        @(negedge clk);
        chk("illegal_ext", external, 1'b0);
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_i = 8'd0; cmd_j = 8'd0;
        cmd_addr = 10'd0; cmd_len = 11'd0; wr_valid = 1'b0; wr_data = 16'd0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 1024; a++)
                ref_mem[b][a] = init_word(b, a);
        repeat (3) @(posedge clk); #1;
        chk("rst_outs", {cmd_ready, busy, external, WEA, done, err, rd_valid, wr_ready}, 8'd0);
        chk("rst_addra", ADDRA, 10'd0);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("idle_ready", cmd_ready, 1'b1);

        do_write(8'd1, 8'd0, 10'h010, 4, 16'hA000, 1'b1, 1'b0);
        do_read(8'd1, 8'd0, 10'h010, 4, 0);
        do_read(8'd1, 8'd0, 10'h010, 8, 1);
        do_write(8'd0, 8'd1, 10'h3FE, 4, 16'hB000, 1'b1, 1'b0);
        do_read(8'd0, 8'd1, 10'h3FE, 4, 0);
        do_illegal(8'd0, 8'd0, 11'd0);
        do_illegal(8'(TILE_DIM), 8'd0, 11'd3);

        begin : reset_mid_burst
            int acc;
            rd_mode = 0;
            issue_cmd(1'b1, 8'd1, 8'd1, 10'h100, 11'd6, acc);
            for (int k = 0; k < 2; k++) begin
                wr_valid = 1'b1; wr_data = 16'hC000 + 16'(k);
                exp_wr.push_back({8'd1, 8'd1, 10'h100 + 10'(k), 16'hC000 + 16'(k)});
                ref_mem[3][10'h100 + 10'(k)] = 16'hC000 + 16'(k);
                @(posedge clk); #1;
            end
            wr_valid = 1'b1; wr_data = 16'hC002;
            #2 reset = 1'b0;
            #1;
            chk("rst_mid_ext", external, 1'b0);
            chk("rst_mid_wea", WEA, 1'b0);
            chk("rst_mid_busy", busy, 1'b0);
            wr_valid = 1'b0;
            @(negedge clk); reset = 1'b1;
            repeat (2) @(posedge clk); #1;
            chk("rst_mid_ready", cmd_ready, 1'b1);
            do_read(8'd1, 8'd1, 10'h100, 6, 0);
            do_write(8'd1, 8'd1, 10'h100, 6, 16'hD000, 1'b1, 1'b0);
            do_read(8'd1, 8'd1, 10'h100, 6, 2);
        end

        for (int n = 0; n < 24; n++) begin
            logic [7:0] ri, rj;
            logic [9:0] ra;
            int rl;
            ri = 8'($urandom_range(0, 1));
            rj = 8'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? 10'h3FA + 10'($urandom_range(0, 5)) : 10'($urandom);
            rl = $urandom_range(1, 10);
            case ($urandom_range(0, 7))
                0:       do_illegal(ri, 8'(TILE_DIM) + rj, 11'(rl));
                1, 2, 3: do_write(ri, rj, ra, rl, 16'd0, 1'b0, 1'($urandom_range(0, 1)));
                default: do_read(ri, rj, ra, rl, $urandom_range(0, 2));
            endcase
        end

        repeat (5) @(negedge clk);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("done_queue_empty", exp_done_err.size(), 0);
        chk("port_b_tied", {WEB, ADDRB, DIB}, 27'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_bram_port_master.md
# tile_bram_port_master

Host-side initiator for a tile's external BRAM port. It accepts one block-transfer command at a time and drives the tile's `external`, `BRAM_i`, `BRAM_j`, `WEA`, `ADDRA` and `DIA` inputs to move a burst of 16-bit words. Writes are accepted from a valid/ready input stream; reads return `DOA` on a valid/ready output stream with backpressure. It sits between the host/DMA fabric and one tile, and loads operands before `start` and unloads results after the tile FSM finishes.

## Interface
- Parameters:
  - `TILE_DIM`, default 2: PE blocks per tile side; `cmd_i`/`cmd_j` must be < `TILE_DIM`.
  - `ADDR_W`, default 10: BRAM address width.
  - `DATA_W`, default 16: BRAM word width.
- Ports (clock and reset first):
  - `clk` in 1: single clock.
  - `reset` in 1: asynchronous, active-low reset.
  - `cmd_valid` in 1: command offered.
  - `cmd_ready` out 1: high only in IDLE.
  - `cmd_write` in 1: 1 = write burst, 0 = read burst.
  - `cmd_i`, `cmd_j` in 8 each: target block row and column.
  - `cmd_addr` in `ADDR_W`: start address.
  - `cmd_len` in `ADDR_W+1`: word count, 1..1024; 0 is illegal.
  - `wr_valid`, `wr_ready` in/out 1: write-data handshake.
  - `wr_data` in `DATA_W`: write word.
  - `rd_valid`, `rd_ready` out/in 1: read-data handshake.
  - `rd_data` out `DATA_W`: read word.
  - `done` out 1: one-cycle pulse when a command completes.
  - `err` out 1: valid with `done`; set for `cmd_len==0` or out-of-range i/j.
  - `busy` out 1: high whenever the state is not IDLE.
  - `external` out 1: tile BRAM ownership.
  - `BRAM_i`, `BRAM_j` out 8 each: block select.
  - `WEA` out 1: port-A write enable.
  - `ADDRA` out `ADDR_W`: port-A address.
  - `DIA` out `DATA_W`: port-A write data.
  - `DOA` in `DATA_W`: port-A read data.
  - `WEB` out 1, `ADDRB` out `ADDR_W`, `DIB` out `DATA_W`: tied to 0.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN, FIN.
- **Reset values:** every output is 0; the state is IDLE; the FIFO is empty.
- **IDLE:**
  - `cmd_ready=1`.
  - On `cmd_valid`, latch `cmd_*` into `cur_addr`, `remain` and `BRAM_i/j`.
  - If `cmd_len==0` or i/j ≥ `TILE_DIM`, go to FIN with `err=1`.
  - Otherwise go to WRITE or READ.
- **WRITE:**
  - `external=1`, `wr_ready=1`.
  - On each `wr_valid&&wr_ready` cycle, drive `WEA=1`, `ADDRA=cur_addr`, `DIA=wr_data` combinationally in that cycle.
  - After each such cycle: `cur_addr++`, `remain--`.
  - On other cycles `WEA=0`.
  - When the last word is accepted, go to FIN.
- **READ:**
  - `external=1`, `WEA=0`.
  - A read is issued by presenting `ADDRA=cur_addr`.
  - Issue condition: `remain>0` and (FIFO count + in-flight − pop this cycle) < 2.
  - `DOA` for an issued address is captured into the FIFO on the next cycle.
  - Once the last read is issued, go to DRAIN.
- **DRAIN:**
  - `external=1`.
  - Wait until no read is in flight and the FIFO is empty, then go to FIN.
- **FIN:**
  - `done=1` for one cycle; `err` as latched.
  - `external=0`; return to IDLE.
- **Read FIFO:**
  - 2 entries.
  - `rd_valid` = FIFO not empty; `rd_data` = head entry.
  - Pop on `rd_valid&&rd_ready`.
  - Push and pop may occur in the same cycle.
- **Address arithmetic:** `cur_addr` wraps from 1023 to 0, with no error; the length is honoured.
- **Stability:** `BRAM_i/j` are held constant from command acceptance until FIN.
- **`external` during FIN:** low.
- **Host obligation:** the host does not assert the tile `start` while `busy=1`.

## Timing
- Command accepted at edge N; first BRAM activity is possible in cycle N+1.
- **Write:**
  - One word per cycle while `wr_valid` is held high.
  - L-word write: FIN occurs in the cycle after the last accepted word.
- **Read:**
  - 1-cycle BRAM latency.
  - With `rd_ready` held high, the first `rd_valid` appears 2 cycles after acceptance, followed by 1 word per cycle.
  - An L-word read completes FIN L+2 cycles after acceptance.
- **Backpressure:** when `rd_ready=0`, at most 2 words are buffered and issue stalls; no word is dropped or duplicated.
- **Reset mid-burst:** forces IDLE immediately (asynchronous); `external` and `WEA` drop to 0 and the FIFO is cleared.

## Test plan
- **Write burst:** cmd write i=1, j=0, addr=0x010, len=4, data 0xA000..0xA003 back-to-back.
  - `WEA` high for 4 cycles at `ADDRA` 0x010..0x013 with `BRAM_i/j=1/0`.
  - `done` pulse with `err=0`.
- **Readback:** cmd read of the same region with `rd_ready=1`.
  - `rd_data` = 0xA000, 0xA001, 0xA002, 0xA003 on consecutive cycles, first valid 2 cycles after acceptance.
- **Backpressure:** read len=8 with `rd_ready` toggled 1,0,0,1,…
  - All 8 words delivered in order.
  - `ADDRA` issue never exceeds 2 outstanding.
- **Wrap:** write addr=0x3FE, len=4.
  - `ADDRA` sequence 0x3FE, 0x3FF, 0x000, 0x001.
- **Illegal commands:** `cmd_len=0`; separately, `cmd_i=TILE_DIM`.
  - No `WEA`, `external` stays 0.
  - `done=1` and `err=1` one cycle after acceptance.
- **Reset mid-burst:** assert `reset=0` during the third word of a 6-word write.
  - `external`, `WEA` and `busy` go to 0 asynchronously.
  - After release, `cmd_ready=1` and a new command executes normally.
